// File: rtl/sram_param_hs.sv
// Purpose: parametrised word-addressed scratchpad SRAM, valid/ready request channel, in-order read responses.
// Latency: an accepted read shows rsp_valid RD_LAT cycles later when no older responses are pending.
// Backpressure: req_ready drops once RD_LAT+1 reads are unpopped; the response FIFO holds its head while !rsp_ready.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_web/req_addr/req_wdata  active-low byte enables (all ones = read), word address, write data
//   rsp_valid/rsp_ready         read response handshake
//   rsp_rdata/rsp_err           read data (0 when out of range), out-of-range flag
//   wr_err                      one-cycle pulse after an out-of-range write is dropped
module sram_param_hs #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16384,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_LAT    = 1,
  localparam int               NB        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NB-1:0]     req_web,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int FD    = RD_LAT + 1;
  localparam int PW    = $clog2(FD);
  localparam int CW    = $clog2(FD + 1);
  // One extra bit so BASE_ADDR+DEPTH cannot wrap at the top of the address space.
  localparam logic [ADDR_W:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] ADDR_HI = ADDR_LO + (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, is_rd, rd_acc, wr_acc, in_range, pop;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  logic              push_vld, push_err;
  logic [DATA_W-1:0] push_dat;

  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_dat [FD];
  logic [FD-1:0]     fifo_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check uses registered state only, so req_ready never depends on rsp_ready or req_valid.
  assign req_ready = !rst && (outstanding < CW'(FD));
  assign accept    = req_valid && req_ready;
  assign is_rd     = &req_web;
  assign rd_acc    = accept && is_rd;
  assign wr_acc    = accept && !is_rd;
  assign in_range  = ({1'b0, req_addr} >= ADDR_LO) && ({1'b0, req_addr} < ADDR_HI);
  assign idx       = IDX_W'(req_addr - BASE_ADDR);
  assign rd_word   = in_range ? mem[idx] : '0;

  // Array is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (!req_web[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_acc && !in_range;
  end

  // Read word is captured at the accept edge, then delayed RD_LAT-1 stages before entering the FIFO.
  if (RD_LAT == 1) begin : g_no_pipe
    assign push_vld = rd_acc;
    assign push_err = !in_range;
    assign push_dat = rd_word;
  end else begin : g_pipe
    logic [RD_LAT-2:0] p_vld, p_err;
    logic [DATA_W-1:0] p_dat [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        p_vld <= '0;
        p_err <= '0;
      end else begin
        p_vld[0] <= rd_acc;
        p_err[0] <= !in_range;
        p_dat[0] <= rd_word;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          p_vld[i] <= p_vld[i-1];
          p_err[i] <= p_err[i-1];
          p_dat[i] <= p_dat[i-1];
        end
      end
    end

    assign push_vld = p_vld[RD_LAT-2];
    assign push_err = p_err[RD_LAT-2];
    assign push_dat = p_dat[RD_LAT-2];
  end

  assign rsp_valid = !rst && (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_dat[rd_ptr] : '0;
  assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (push_vld) begin
        fifo_dat[wr_ptr] <= push_dat;
        fifo_err[wr_ptr] <= push_err;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({push_vld, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Credits bound the FIFO occupancy, so a push into a full FIFO without a pop is impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_vld && !pop && fifo_cnt == CW'(FD)));

endmodule

// File: tb/tb_sram_param_hs.sv
module tb_sram_param_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Instances 0..2 are 32-bit: 0 = RD_LAT 1, 1 = RD_LAT 3, 2 = RD_LAT 2 with BASE 0x100 / DEPTH 256.
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [3:0]  req_web   [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        wr_err    [3];

  // 64-bit instance, RD_LAT 4, DEPTH 1024, separate reset.
  logic        rst_d;
  logic        req_valid_d, req_ready_d, rsp_valid_d, rsp_ready_d, rsp_err_d, wr_err_d;
  logic [7:0]  req_web_d;
  logic [31:0] req_addr_d;
  logic [63:0] req_wdata_d, rsp_rdata_d;

  sram_param_hs #(.DATA_W(32), .DEPTH(16384), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_web(req_web[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .wr_err(wr_err[0]));

  sram_param_hs #(.DATA_W(32), .DEPTH(256), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_web(req_web[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .wr_err(wr_err[1]));

  sram_param_hs #(.DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h100), .RD_LAT(2)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_web(req_web[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .wr_err(wr_err[2]));

  sram_param_hs #(.DATA_W(64), .DEPTH(1024), .RD_LAT(4)) u_d (
    .clk(clk), .rst(rst_d), .req_valid(req_valid_d), .req_ready(req_ready_d),
    .req_web(req_web_d), .req_addr(req_addr_d), .req_wdata(req_wdata_d),
    .rsp_valid(rsp_valid_d), .rsp_ready(rsp_ready_d), .rsp_rdata(rsp_rdata_d),
    .rsp_err(rsp_err_d), .wr_err(wr_err_d));

  typedef struct {
    int          k;
    logic [31:0] dat;
    logic        err;
    int          cyc;
  } rsp_t;

  rsp_t mon_q[$];
  rsp_t mon_r;

  // Record every popped response of the 32-bit instances with the cycle it was taken.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid[k] && rsp_ready[k]) begin
        mon_r.k   = k;
        mon_r.dat = rsp_rdata[k];
        mon_r.err = rsp_err[k];
        mon_r.cyc = cyc;
        mon_q.push_back(mon_r);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int k, input logic [3:0] web, input logic [31:0] addr,
                       input logic [31:0] wdata, output int c);
    int n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("issue_timeout", 64'(req_ready[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_web[k]   = web;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    c = cyc;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic get_rsp(output rsp_t r);
    int n = 0;
    while (mon_q.size() == 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (mon_q.size() == 0) begin
      check("rsp_timeout", 64'(mon_q.size()), 64'd1);
      r.k = -1; r.dat = '0; r.err = 1'b0; r.cyc = -1;
    end else begin
      r = mon_q.pop_front();
    end
  endtask

  task automatic issue_d(input logic [7:0] web, input logic [31:0] addr,
                         input logic [63:0] wdata, output int c);
    int n = 0;
    @(negedge clk);
    while (!req_ready_d && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("issue_d_timeout", 64'(req_ready_d), 64'd1);
    req_valid_d = 1'b1;
    req_web_d   = web;
    req_addr_d  = addr;
    req_wdata_d = wdata;
    c = cyc;
    @(posedge clk);
    #1 req_valid_d = 1'b0;
  endtask

  task automatic get_d(output logic [63:0] dat, output int cy);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid_d && n < 100);
    if (!rsp_valid_d) check("rsp_d_timeout", 64'(rsp_valid_d), 64'd1);
    dat = rsp_rdata_d;
    cy  = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c, c0, cy, n_acc, cnt;
    rsp_t        r;
    logic [63:0] d;

    rst = 1'b1;
    rst_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_web[k] = 4'hF; req_addr[k] = '0; req_wdata[k] = '0;
    end
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1; rsp_ready[2] = 1'b0;
    req_valid_d = 1'b0; req_web_d = 8'hFF; req_addr_d = '0; req_wdata_d = '0; rsp_ready_d = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(req_ready[0]), 64'd0);
    check("rst_valid",  64'(rsp_valid[0]), 64'd0);
    check("rst_rdata",  64'(rsp_rdata[0]), 64'd0);
    check("rst_err",    64'(rsp_err[0]),   64'd0);
    check("rst_wr_err", 64'(wr_err[0]),    64'd0);
    check("rst_ready_d", 64'(req_ready_d), 64'd0);
    rst = 1'b0;
    rst_d = 1'b0;
    #1;
    check("rel_ready",   64'(req_ready[0]), 64'd1);
    check("rel_ready_d", 64'(req_ready_d),  64'd1);

    // Byte merge and read-after-write, RD_LAT 1
    issue(0, 4'b0000, 32'h10, 32'h11223344, c);
    issue(0, 4'b1010, 32'h10, 32'hAABBCCDD, c);
    issue(0, 4'b1111, 32'h10, 32'h0, c);
    get_rsp(r);
    check("merge_dat", 64'(r.dat), 64'h11BB33DD);
    check("merge_err", 64'(r.err), 64'd0);
    check("merge_lat", 64'(r.cyc), 64'(c + 1));

    // Streaming, RD_LAT 3
    for (int i = 0; i < 8; i++) issue(1, 4'b0000, 32'(i), 32'hB000_0000 + 32'(i), c);
    c0 = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1, 4'b1111, 32'(i), 32'h0, c);
      if (i == 0) c0 = c;
      check("strm_acc", 64'(c), 64'(c0 + i));
    end
    for (int i = 0; i < 8; i++) begin
      get_rsp(r);
      check("strm_dat", 64'(r.dat), 64'hB000_0000 + 64'(i));
      check("strm_lat", 64'(r.cyc), 64'(c0 + 3 + i));
    end

    // Backpressure, RD_LAT 2, base 0x100
    for (int i = 0; i < 3; i++) issue(2, 4'b0000, 32'h100 + 32'(i), 32'hC000_0000 + 32'(i), c);
    issue(2, 4'b0000, 32'h1FF, 32'h5A5A5A5A, c);
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        req_valid[2] = 1'b1;
        req_web[2]   = 4'hF;
        req_addr[2]  = 32'h100 + 32'(n_acc);
        n_acc++;
      end else begin
        req_valid[2] = 1'b0;
      end
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("bp_accepted", 64'(n_acc), 64'd3);
    check("bp_ready_low", 64'(req_ready[2]), 64'd0);
    check("bp_head_vld", 64'(rsp_valid[2]), 64'd1);
    check("bp_head_dat", 64'(rsp_rdata[2]), 64'hC000_0000);
    repeat (3) @(negedge clk);
    check("bp_hold_dat", 64'(rsp_rdata[2]), 64'hC000_0000);
    check("bp_hold_err", 64'(rsp_err[2]), 64'd0);
    rsp_ready[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_rsp(r);
      check("bp_dat", 64'(r.dat), 64'hC000_0000 + 64'(i));
    end
    @(negedge clk);
    check("bp_ready_back", 64'(req_ready[2]), 64'd1);

    // Out of range, base 0x100 depth 256
    issue(2, 4'b0000, 32'h200, 32'hDEADBEEF, c);
    @(negedge clk);
    check("wr_err_pulse", 64'(wr_err[2]), 64'd1);
    @(negedge clk);
    check("wr_err_clear", 64'(wr_err[2]), 64'd0);
    issue(2, 4'hF, 32'h100, 32'h0, c);
    get_rsp(r);
    check("oor_no_alias", 64'(r.dat), 64'hC000_0000);
    issue(2, 4'hF, 32'h0FF, 32'h0, c);
    get_rsp(r);
    check("oor_lo_dat", 64'(r.dat), 64'd0);
    check("oor_lo_err", 64'(r.err), 64'd1);
    issue(2, 4'hF, 32'h1FF, 32'h0, c);
    get_rsp(r);
    check("top_err", 64'(r.err), 64'd0);
    check("top_dat", 64'(r.dat), 64'h5A5A5A5A);

    // 64-bit lanes, RD_LAT 4
    issue_d(8'h00, 32'd5, 64'h0123456789ABCDEF, c);
    issue_d(8'h0F, 32'd5, 64'hFFEEDDCCBBAA9988, c);
    issue_d(8'hFF, 32'd5, 64'h0, c);
    get_d(d, cy);
    check("w64_dat", d, 64'hFFEEDDCC89ABCDEF);
    check("w64_lat", 64'(cy), 64'(c + 4));

    // Reset with reads in flight
    rsp_ready_d = 1'b0;
    for (int i = 0; i < 3; i++) issue_d(8'hFF, 32'd5, 64'h0, c);
    repeat (2) @(negedge clk);
    check("pre_rst_vld", 64'(rsp_valid_d), 64'd1);
    rst_d       = 1'b1;
    req_valid_d = 1'b1;
    req_web_d   = 8'h00;
    req_addr_d  = 32'd5;
    req_wdata_d = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check("in_rst_vld",   64'(rsp_valid_d), 64'd0);
    check("in_rst_rdata", rsp_rdata_d,      64'd0);
    check("in_rst_ready", 64'(req_ready_d), 64'd0);
    @(negedge clk);
    rst_d       = 1'b0;
    req_valid_d = 1'b0;
    rsp_ready_d = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready_d), 64'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_d) cnt++;
    end
    check("post_rst_stale", 64'(cnt), 64'd0);
    issue_d(8'hFF, 32'd5, 64'h0, c);
    get_d(d, cy);
    check("post_rst_dat", d, 64'hFFEEDDCC89ABCDEF);
    check("post_rst_lat", 64'(cy), 64'(c + 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_param_hs.md
Name: sram_param_hs

Overview:
- Parametrised successor of the team's 64 KB word-addressed SRAM model with active-low byte write enables.
- Generalises data width, depth and base address, and makes read latency configurable.
- Replaces the free-running port with a valid/ready request channel and a backpressured, in-order read-response channel; out-of-range accesses are flagged as errors.
- Sits between an AXI/bus slave shim or accelerator DMA and the local scratchpad array.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- NB, DATA_W/8, byte lanes (derived; not overridden).
- DEPTH, 16384, number of words.
- ADDR_W, 32, request word-address width.
- BASE_ADDR, 0, first valid word address.
- RD_LAT, 1, accepted-read to earliest rsp_valid, in cycles; legal 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_web  in  NB  byte write enables, active-low; all ones = read, any zero = write.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  response is for an out-of-range read.
- wr_err  out  1  one-cycle pulse: out-of-range write dropped.

Behaviour:
- Interface is fixed: one clock, clk; reset is rst, synchronous and active-high.
- A request is accepted on a cycle with req_valid && req_ready.
- In range: BASE_ADDR <= req_addr < BASE_ADDR+DEPTH. Index = req_addr-BASE_ADDR, truncated to clog2(DEPTH) bits.
- Writes:
  - Each lane with req_web[i]==0 updates bits [8i+7:8i] at the accept edge; other lanes are unchanged.
  - A write produces no response.
  - Out-of-range write: array untouched; wr_err=1 the following cycle only.
- Reads:
  - The word is sampled at the accept edge and carried through RD_LAT-1 pipeline stages into a response FIFO of depth RD_LAT+1.
  - Head of the FIFO drives rsp_valid/rsp_rdata/rsp_err. Pop on rsp_valid && rsp_ready.
  - Responses are strictly in acceptance order.
  - Out-of-range read: rsp_rdata=0, rsp_err=1.
  - While rsp_valid && !rsp_ready, rsp_rdata and rsp_err hold stable.
- Latency:
  - Read accepted at edge T, with no older responses pending → rsp_valid high in cycle T+RD_LAT.
  - With RD_LAT=1 this matches the legacy one-cycle read.
- Credit counter `outstanding`:
  - Counts accepted reads not yet popped.
  - +1 on read accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
  - req_ready = !rst && (outstanding < RD_LAT+1). Registered-state only; no combinational path from rsp_ready or req_valid.
  - Writes also require req_ready (preserves ordering) but do not consume credit.
- Throughput: with rsp_ready held high, one request per cycle indefinitely.
- Read-after-write:
  - A read accepted the cycle after a write to the same word returns the new data, with byte merge applied.
  - Only one request per cycle, so no same-cycle conflict exists.
- FIFO full: outstanding==RD_LAT+1 → req_ready=0. The FIFO can never overflow; an assertion checks this.
- Reset (any cycle, including mid-burst):
  - Pipeline, FIFO and outstanding cleared.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0, req_ready=0 while rst is high.
  - Requests presented during reset are ignored; in-flight reads are discarded.
  - Array contents are not reset and remain intact.
  - req_ready=1 the first cycle after rst falls.
- Array contents are undefined before the first write; the bench treats unwritten reads as don't-care.

Test Plan:
- Byte merge, RD_LAT=1: write 0x11223344 @0x10 web=0000; write 0xAABBCCDD @0x10 web=1010 (lanes 0 and 2 written); read @0x10 → rsp_rdata=0x11BB33DD at T+1, rsp_err=0.
- Streaming, RD_LAT=3, rsp_ready=1: reads @0..7 on consecutive cycles → req_ready never drops; 8 responses on consecutive cycles from T+3, in order.
- Backpressure, RD_LAT=2: rsp_ready=0, issue reads back-to-back → exactly 3 accepted, then req_ready=0 and rsp_rdata stable. Raise rsp_ready → 3 responses in order, req_ready returns to 1.
- Out of range, BASE_ADDR=0x100, DEPTH=256: write @0x200 → wr_err pulse 1 cycle, no array change. Read @0x0FF → rsp_rdata=0, rsp_err=1. Read @0x1FF → rsp_err=0.
- Reset mid-operation, RD_LAT=4: 3 reads in flight, assert rst 1 cycle → rsp_valid=0 and no stale responses after release. Data written before reset reads back unchanged.
- Parameter sweep DATA_W=64, DEPTH=1024: web=0x0F write, then read → only the upper 4 bytes are updated (web bits 4..7 are low).
